// File: rtl/bcd_scan_display.sv
// Scanned 3-digit common-anode 7-segment driver with shadow/display double buffering.
// Optional leading-zero blanking when BCD_SCAN_BLANK_EN is defined.
module bcd_scan_display #(
   parameter int unsigned PRESCALE   = 1000,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [1:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       frame
);

   localparam int unsigned MAXC = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC);
   localparam logic [CW-1:0] PS_LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
   localparam bit HAS_GAP = (GAP_CYCLES != 0);

   typedef enum logic [2:0] {
      S_ONES, S_GAP0, S_TENS, S_GAP1, S_HUND, S_GAP2
   } state_t;

   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic          w_last;
   logic          w_xfer;

   logic [1:0] r_sh_h, r_disp_h;
   logic [3:0] r_sh_t, r_sh_o, r_disp_t, r_disp_o;
   logic [6:0] r_seg, w_seg;
   logic [2:0] r_an, w_an;
   logic       r_frame;
   logic       w_blank_h, w_blank_t;

   function automatic logic [6:0] f_dec(input logic [3:0] d);
      case (d)
         4'd0:    f_dec = 7'b1000000;
         4'd1:    f_dec = 7'b1111001;
         4'd2:    f_dec = 7'b0100100;
         4'd3:    f_dec = 7'b0110000;
         4'd4:    f_dec = 7'b0011001;
         4'd5:    f_dec = 7'b0010010;
         4'd6:    f_dec = 7'b0000010;
         4'd7:    f_dec = 7'b1111000;
         4'd8:    f_dec = 7'b0000000;
         4'd9:    f_dec = 7'b0010000;
         default: f_dec = 7'b0111111;
      endcase
   endfunction

   // State register and phase counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_ONES;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Next state; gap phases are bypassed entirely when GAP_CYCLES is zero
   always_comb begin
      w_next = r_state;
      w_last = 1'b0;
      case (r_state)
         S_ONES: begin
            w_last = (r_cnt == PS_LAST);
            if (w_last) w_next = HAS_GAP ? S_GAP0 : S_TENS;
         end
         S_GAP0: begin
            w_last = (r_cnt == GAP_LAST);
            if (w_last) w_next = S_TENS;
         end
         S_TENS: begin
            w_last = (r_cnt == PS_LAST);
            if (w_last) w_next = HAS_GAP ? S_GAP1 : S_HUND;
         end
         S_GAP1: begin
            w_last = (r_cnt == GAP_LAST);
            if (w_last) w_next = S_HUND;
         end
         S_HUND: begin
            w_last = (r_cnt == PS_LAST);
            if (w_last) w_next = HAS_GAP ? S_GAP2 : S_ONES;
         end
         S_GAP2: begin
            w_last = (r_cnt == GAP_LAST);
            if (w_last) w_next = S_ONES;
         end
         default: begin
            w_last = 1'b1;
            w_next = S_ONES;
         end
      endcase
   end

   assign w_xfer = (r_state != S_ONES) && (w_next == S_ONES);

`ifdef BCD_SCAN_BLANK_EN
   assign w_blank_h = (r_disp_h == 2'd0);
   assign w_blank_t = w_blank_h && (r_disp_t == 4'd0);
`else
   assign w_blank_h = 1'b0;
   assign w_blank_t = 1'b0;
`endif

   // Output decode from current state; registered below
   always_comb begin
      w_an  = 3'b111;
      w_seg = 7'h7F;
      case (r_state)
         S_ONES: begin
            w_an  = 3'b110;
            w_seg = f_dec(r_disp_o);
         end
         S_TENS: begin
            w_an  = 3'b101;
            w_seg = w_blank_t ? 7'h7F : f_dec(r_disp_t);
         end
         S_HUND: begin
            w_an  = 3'b011;
            w_seg = w_blank_h ? 7'h7F : f_dec({2'b00, r_disp_h});
         end
         default: begin
            w_an  = 3'b111;
            w_seg = 7'h7F;
         end
      endcase
   end

   // A load coinciding with the transfer edge lands in shadow only; display takes the old shadow
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_h   <= '0;
         r_sh_t   <= '0;
         r_sh_o   <= '0;
         r_disp_h <= '0;
         r_disp_t <= '0;
         r_disp_o <= '0;
         r_frame  <= 1'b0;
         r_an     <= '1;
         r_seg    <= '1;
      end else begin
         if (load) begin
            r_sh_h <= hundreds;
            r_sh_t <= tens;
            r_sh_o <= ones;
         end
         if (w_xfer) begin
            r_disp_h <= r_sh_h;
            r_disp_t <= r_sh_t;
            r_disp_o <= r_sh_o;
         end
         r_frame <= w_xfer;
         r_an    <= w_an;
         r_seg   <= w_seg;
      end
   end

   assign seg   = r_seg;
   assign an    = r_an;
   assign frame = r_frame;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with PRESCALE=4, GAP_CYCLES=1 (scan period 15).
module tb_bcd_scan_display;

   logic       clk;
   logic       rst;
   logic       load;
   logic [1:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [6:0] seg;
   logic [2:0] an;
   logic       frame;

   int n_checks = 0;
   int n_fail   = 0;
   int n;

`ifdef BCD_SCAN_BLANK_EN
   localparam logic [6:0] ZB = 7'h7F;
`else
   localparam logic [6:0] ZB = 7'h40;
`endif

   bcd_scan_display #(
      .PRESCALE   (4),
      .GAP_CYCLES (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones),
      .seg      (seg),
      .an       (an),
      .frame    (frame)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) check_eq("an_onehot0", 32'($countones(~an) <= 1), 32'd1);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame(output int cnt);
      cnt = 0;
      while (frame !== 1'b1 && cnt < 40) begin
         tick();
         cnt++;
      end
      check_eq("frame_seen", 32'(frame), 32'd1);
   endtask

   // Entered on a frame-pulse sample; walks one full scan and ends on the next frame sample
   task automatic scan_check(input string tag, input logic [6:0] s_o, input logic [6:0] s_t,
                             input logic [6:0] s_h, input int ld_k, input logic [1:0] lh,
                             input logic [3:0] lt, input logic [3:0] lo);
      logic [2:0] e_an;
      logic [6:0] e_seg;
      for (int k = 1; k <= 15; k++) begin
         tick();
         load = 1'b0;
         if (k <= 4)       begin e_an = 3'b110; e_seg = s_o;   end
         else if (k == 5)  begin e_an = 3'b111; e_seg = 7'h7F; end
         else if (k <= 9)  begin e_an = 3'b101; e_seg = s_t;   end
         else if (k == 10) begin e_an = 3'b111; e_seg = 7'h7F; end
         else if (k <= 14) begin e_an = 3'b011; e_seg = s_h;   end
         else              begin e_an = 3'b111; e_seg = 7'h7F; end
         check_eq($sformatf("%s_an_k%0d", tag, k), 32'(an), 32'(e_an));
         check_eq($sformatf("%s_seg_k%0d", tag, k), 32'(seg), 32'(e_seg));
         check_eq($sformatf("%s_frame_k%0d", tag, k), 32'(frame), 32'(k == 15));
         if (k == ld_k) begin
            load     = 1'b1;
            hundreds = lh;
            tens     = lt;
            ones     = lo;
         end
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; hundreds = '0; tens = '0; ones = '0;
      repeat (3) tick();
      check_eq("rst_an", 32'(an), 32'h7);
      check_eq("rst_seg", 32'(seg), 32'h7F);
      check_eq("rst_frame", 32'(frame), 32'd0);

      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check_eq($sformatf("rel_an_k%0d", k), 32'(an),
                  32'((k <= 4) ? 3'b110 : (k == 5) ? 3'b111 : 3'b101));
         check_eq($sformatf("rel_seg_k%0d", k), 32'(seg),
                  32'((k <= 4) ? 7'h40 : (k == 5) ? 7'h7F : ZB));
         check_eq($sformatf("rel_frame_k%0d", k), 32'(frame), 32'd0);
      end

      load = 1'b1; hundreds = 2'd2; tens = 4'd5; ones = 4'd5;
      tick();
      load = 1'b0;
      wait_frame(n);
      check_eq("first_frame_lat", 32'(n), 32'd8);

      scan_check("v255", 7'h12, 7'h12, 7'h24, 2, 2'd1, 4'd2, 4'd3);
      scan_check("v123", 7'h30, 7'h24, 7'h79, 7, 2'd0, 4'd0, 4'd7);
      scan_check("v007a", 7'h78, ZB, ZB, 14, 2'd2, 4'd6, 4'd9);
      scan_check("v007b", 7'h78, ZB, ZB, 0, 2'd0, 4'd0, 4'd0);
      scan_check("v269", 7'h10, 7'h02, 7'h24, 3, 2'd1, 4'd4, 4'd8);
      scan_check("v148", 7'h00, 7'h19, 7'h79, 3, 2'd0, 4'hA, 4'hF);
      scan_check("v0AF", 7'h3F, 7'h3F, ZB, 0, 2'd0, 4'd0, 4'd0);

      repeat (6) tick();
      rst = 1'b1;
      tick();
      check_eq("midrst_an", 32'(an), 32'h7);
      check_eq("midrst_seg", 32'(seg), 32'h7F);
      check_eq("midrst_frame", 32'(frame), 32'd0);
      rst = 1'b0;
      wait_frame(n);
      check_eq("midrst_frame_lat", 32'(n), 32'd15);
      scan_check("v000", 7'h40, ZB, ZB, 0, 2'd0, 4'd0, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
